// File: rtl/intrapred_sched.sv
// -----------------------------------------------------------------------------
// intrapred_sched
//
// Frame-level scheduler for the intra-prediction pipeline. Walks macroblock
// numbers 0..num_mbs-1 through the extract -> mode -> residual -> SAD -> save
// chain, drives the shared enable/mbnumber inputs of that chain and tracks
// which macroblock occupies each pipeline stage.
//
// FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   RUN   : one new macroblock is injected into stage 0 on every advance.
//   DRAIN : bubbles are injected until the last real macroblock has retired.
//   DONE  : single-cycle frame_done pulse.
//
// Parameters
//   MB_NUMBER_BITS   macroblock index is MB_NUMBER_BITS+1 bits wide
//   PIPE_DEPTH       number of datapath stages tracked (>= 2)
//
// Ports
//   clk               clock
//   reset             asynchronous, active-high reset
//   start             one-cycle frame request, honoured only in IDLE
//   abort             cancel the current frame (wins over start in IDLE)
//   num_mbs           macroblocks in the frame, sampled on accepted start
//   pipe_ready        datapath can advance this cycle (saver backpressure)
//   enable            advance strobe to all datapath stages (combinational)
//   mbnumber          macroblock being injected into stage 0
//   stage_valid       bit i set when stage i holds a real macroblock
//   mb_retired        a macroblock leaves the last stage this cycle (comb.)
//   retired_mbnumber  tag of the last stage (meaningful with mb_retired)
//   busy              state is not IDLE
//   frame_done        one-cycle pulse at frame completion
//
// Optional feature (macro INTRAPRED_SCHED_PERF_EN):
//   stall_cycles      RUN/DRAIN cycles with pipe_ready low, saturating
//   frame_cycles      busy cycles of the current/last frame, saturating
//   Both clear on an accepted start and hold while IDLE.
// -----------------------------------------------------------------------------
module intrapred_sched #(
   parameter int MB_NUMBER_BITS = 12,
   parameter int PIPE_DEPTH     = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [MB_NUMBER_BITS:0] num_mbs,
   input  logic                    pipe_ready,
   output logic                    enable,
   output logic [MB_NUMBER_BITS:0] mbnumber,
   output logic [PIPE_DEPTH-1:0]   stage_valid,
   output logic                    mb_retired,
   output logic [MB_NUMBER_BITS:0] retired_mbnumber,
   output logic                    busy,
   output logic                    frame_done
`ifdef INTRAPRED_SCHED_PERF_EN
   ,
   output logic [31:0]             stall_cycles,
   output logic [31:0]             frame_cycles
`endif
);

   typedef logic [MB_NUMBER_BITS:0] mb_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam mb_t MB_ONE = mb_t'(1);

   state_t                state;
   mb_t                   next_mb;
   mb_t                   num_mbs_q;
   mb_t                   last_mb;
   mb_t                   stage_tag [PIPE_DEPTH];
   logic                  advance;
   logic                  start_ok;
   logic [PIPE_DEPTH-1:0] drain_shift;

   // Advance strobe: only while the pipe is being filled or drained, and only
   // when the saver stage can accept another macroblock.
   assign advance  = ((state == S_RUN) || (state == S_DRAIN)) && pipe_ready;
   assign enable   = advance;
   assign start_ok = (state == S_IDLE) && start && !abort;

   // num_mbs_q is never zero while in RUN, so this never underflows there.
   assign last_mb  = num_mbs_q - MB_ONE;

   // Valid vector as it will look after a DRAIN advance (bubble enters
   // stage 0). All-zero means the last real macroblock is retiring now.
   assign drain_shift = {stage_valid[PIPE_DEPTH-2:0], 1'b0};

   assign mbnumber         = next_mb;
   assign mb_retired       = advance & stage_valid[PIPE_DEPTH-1];
   assign retired_mbnumber = stage_tag[PIPE_DEPTH-1];

   // ---------------------------------------------------------------------------
   // Scheduler FSM, issue counter and stage tracking
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // the shift below reads every stage's pre-edge value regardless of order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         next_mb     <= '0;
         num_mbs_q   <= '0;
         stage_valid <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         // NOTE: the tag shift register is a handful of flops, not a RAM, so
         // it is reset along with everything else; this keeps
         // retired_mbnumber at zero out of reset.
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_tag[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  next_mb   <= '0;
                  num_mbs_q <= num_mbs;
                  busy      <= 1'b1;
                  if (num_mbs == '0) begin
                     // Empty frame: nothing to issue, report completion now.
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               if (abort) begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  stage_valid <= '0;
               end else if (pipe_ready) begin
                  for (int i = PIPE_DEPTH-1; i > 0; i--) begin
                     stage_tag[i] <= stage_tag[i-1];
                  end
                  stage_tag[0] <= next_mb;
                  stage_valid  <= {stage_valid[PIPE_DEPTH-2:0], 1'b1};
                  next_mb      <= next_mb + MB_ONE;
                  if (next_mb == last_mb) begin
                     state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               if (abort) begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  stage_valid <= '0;
               end else if (pipe_ready) begin
                  // Bubble enters stage 0; its tag is stale and never used.
                  for (int i = PIPE_DEPTH-1; i > 0; i--) begin
                     stage_tag[i] <= stage_tag[i-1];
                  end
                  stage_valid <= drain_shift;
                  if (drain_shift == '0) begin
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               // Completion is already reported; abort here has nothing left
               // to cancel and the FSM returns to IDLE either way.
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state       <= S_IDLE;
               busy        <= 1'b0;
               stage_valid <= '0;
            end
         endcase
      end
   end

`ifdef INTRAPRED_SCHED_PERF_EN
   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic stall_now;

   assign stall_now = ((state == S_RUN) || (state == S_DRAIN)) && !pipe_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         frame_cycles <= '0;
      end else if (state == S_IDLE) begin
         // Hold the last frame's figures until the next frame is accepted.
         if (start_ok) begin
            stall_cycles <= '0;
            frame_cycles <= '0;
         end
      end else begin
         if (frame_cycles != '1) begin
            frame_cycles <= frame_cycles + 32'd1;
         end
         if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_intrapred_sched.sv
// -----------------------------------------------------------------------------
// tb_intrapred_sched
//
// Self-checking bench for intrapred_sched (default parameters).
//   1. Directed vector table: clean 3-MB frame, same frame with two stall
//      cycles, empty frame; explicit expected outputs per cycle.
//   2. Hand-written sequences: abort mid-frame, ignored starts, asynchronous
//      reset while draining.
//   3. Random traffic checked against a frame-level reference model that
//      derives every output from the number of advances made so far.
// Define INTRAPRED_SCHED_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_intrapred_sched;

   localparam int PD = 5;
   localparam int MW = 13;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic [MW-1:0] num_mbs;
   logic          pipe_ready;
   logic          enable;
   logic [MW-1:0] mbnumber;
   logic [PD-1:0] stage_valid;
   logic          mb_retired;
   logic [MW-1:0] retired_mbnumber;
   logic          busy;
   logic          frame_done;
`ifdef INTRAPRED_SCHED_PERF_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   frame_cycles;
`endif

   intrapred_sched dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .num_mbs          (num_mbs),
      .pipe_ready       (pipe_ready),
      .enable           (enable),
      .mbnumber         (mbnumber),
      .stage_valid      (stage_valid),
      .mb_retired       (mb_retired),
      .retired_mbnumber (retired_mbnumber),
      .busy             (busy),
      .frame_done       (frame_done)
`ifdef INTRAPRED_SCHED_PERF_EN
      ,
      .stall_cycles     (stall_cycles),
      .frame_cycles     (frame_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a frame is "active" for a number of advances. Macroblock
   // k enters on advance k and leaves on advance k+PD; the frame is complete
   // after N+PD advances.
   // ---------------------------------------------------------------------------
   typedef enum {M_IDLE, M_ACTIVE, M_DONE} mphase_t;

   mphase_t m_phase = M_IDLE;
   int      m_n     = 0;
   int      m_a     = 0;
   int      m_stall = 0;
   int      m_fcyc  = 0;

   function automatic logic [PD-1:0] exp_valid(input int a, input int n);
      logic [PD-1:0] v;
      v = '0;
      for (int i = 0; i < PD; i++) begin
         if ((a - 1 - i >= 0) && (a - 1 - i < n)) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE;
      m_n     = 0;
      m_a     = 0;
      m_stall = 0;
      m_fcyc  = 0;
   endtask

   task automatic model_update(input logic st, input logic [MW-1:0] n, input logic pr,
                               input logic ab);
      case (m_phase)
         M_IDLE: begin
            if (st && !ab) begin
               m_n     = int'(n);
               m_a     = 0;
               m_stall = 0;
               m_fcyc  = 0;
               m_phase = (n == '0) ? M_DONE : M_ACTIVE;
            end
         end
         M_ACTIVE: begin
            m_fcyc++;
            if (!pr) m_stall++;
            if (ab) begin
               m_phase = M_IDLE;
            end else if (pr) begin
               m_a++;
               if (m_a == m_n + PD) m_phase = M_DONE;
            end
         end
         default: begin
            m_fcyc++;
            m_phase = M_IDLE;
         end
      endcase
   endtask

   task automatic compare_model();
      logic          exp_en;
      logic          exp_ret;
      logic [PD-1:0] exp_sv;
      int            r;
      exp_en  = (m_phase == M_ACTIVE) && pipe_ready;
      r       = m_a - PD;
      exp_ret = exp_en && (r >= 0) && (r < m_n);
      exp_sv  = (m_phase == M_ACTIVE) ? exp_valid(m_a, m_n) : '0;
      check("enable", 32'(enable), 32'(exp_en));
      check("stage_valid", 32'(stage_valid), 32'(exp_sv));
      check("mb_retired", 32'(mb_retired), 32'(exp_ret));
      if (exp_ret) check("retired_mbnumber", 32'(retired_mbnumber), 32'(r));
      if ((m_phase == M_ACTIVE) && (m_a < m_n)) check("mbnumber", 32'(mbnumber), 32'(m_a));
      check("busy", 32'(busy), 32'(m_phase != M_IDLE));
      check("frame_done", 32'(frame_done), 32'(m_phase == M_DONE));
`ifdef INTRAPRED_SCHED_PERF_EN
      check("stall_cycles", stall_cycles, 32'(m_stall));
      check("frame_cycles", frame_cycles, 32'(m_fcyc));
`endif
   endtask

   // One clock cycle: drive inputs just after the edge, compare on the falling
   // edge, advance the model, then move to just after the next rising edge.
   task automatic step(input logic st, input logic [MW-1:0] n, input logic pr, input logic ab);
      start      = st;
      num_mbs    = n;
      pipe_ready = pr;
      abort      = ab;
      @(negedge clk);
      compare_model();
      model_update(st, n, pr, ab);
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          st;
      logic [MW-1:0] n;
      logic          pr;
      logic          en;
      logic          chk_mb;
      logic [MW-1:0] mb;
      logic [PD-1:0] sv;
      logic          ret;
      logic [MW-1:0] tag;
      logic          bsy;
      logic          done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic st, input int n, input logic pr, input logic en,
                               input logic chk_mb, input int mb, input logic [PD-1:0] sv,
                               input logic ret, input int tag, input logic bsy,
                               input logic done);
      vec_t v;
      v.st = st;  v.n = MW'(n);   v.pr = pr;   v.en = en;
      v.chk_mb = chk_mb; v.mb = MW'(mb); v.sv = sv;
      v.ret = ret; v.tag = MW'(tag); v.bsy = bsy; v.done = done;
      vecs.push_back(v);
   endfunction

   int seen_done;

   initial begin
      //  st  n pr en cmb mb  sv        ret tag bsy done
      // Frame A: 3 MBs, no stalls (rows 0..10)
      add(1, 3, 1, 0, 1, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0, 5'b00000, 0, 0, 1, 0);
      add(0, 0, 1, 1, 1, 1, 5'b00001, 0, 0, 1, 0);
      add(0, 0, 1, 1, 1, 2, 5'b00011, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b00111, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b01110, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b11100, 1, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b11000, 1, 1, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b10000, 1, 2, 1, 0);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      // Frame B: 3 MBs, pipe_ready low in cycles 2-3 (rows 11..23)
      add(1, 3, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0, 5'b00000, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 1, 5'b00001, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 1, 5'b00001, 0, 0, 1, 0);
      add(0, 0, 1, 1, 1, 1, 5'b00001, 0, 0, 1, 0);
      add(0, 0, 1, 1, 1, 2, 5'b00011, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b00111, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b01110, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b11100, 1, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b11000, 1, 1, 1, 0);
      add(0, 0, 1, 1, 0, 0, 5'b10000, 1, 2, 1, 0);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      // Frame C: empty frame (rows 24..26)
      add(1, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

      reset      = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      num_mbs    = '0;
      pipe_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // ---- table ------------------------------------------------------------
      for (int i = 0; i < vecs.size(); i++) begin
         start      = vecs[i].st;
         num_mbs    = vecs[i].n;
         pipe_ready = vecs[i].pr;
         abort      = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d enable", i), 32'(enable), 32'(vecs[i].en));
         check($sformatf("vec%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].sv));
         check($sformatf("vec%0d mb_retired", i), 32'(mb_retired), 32'(vecs[i].ret));
         if (vecs[i].ret)
            check($sformatf("vec%0d retired_mbnumber", i), 32'(retired_mbnumber),
                  32'(vecs[i].tag));
         if (vecs[i].chk_mb)
            check($sformatf("vec%0d mbnumber", i), 32'(mbnumber), 32'(vecs[i].mb));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
         check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].done));
`ifdef INTRAPRED_SCHED_PERF_EN
         if (i == 10) begin
            check("perf A frame_cycles", frame_cycles, 32'd9);
            check("perf A stall_cycles", stall_cycles, 32'd0);
         end
         if (i == 23) begin
            check("perf B frame_cycles", frame_cycles, 32'd11);
            check("perf B stall_cycles", stall_cycles, 32'd2);
         end
         if (i == 26) begin
            check("perf C frame_cycles", frame_cycles, 32'd1);
            check("perf C stall_cycles", stall_cycles, 32'd0);
         end
`endif
         model_update(vecs[i].st, vecs[i].n, vecs[i].pr, 1'b0);
         @(posedge clk);
         #1;
      end

      // ---- abort in cycle 4 of a 10-MB frame ---------------------------------
      step(1'b1, 13'd10, 1'b1, 1'b0);
      repeat (3) step(1'b0, 13'd0, 1'b1, 1'b0);
      step(1'b0, 13'd0, 1'b1, 1'b1);
      check("abort stage_valid", 32'(stage_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      seen_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (frame_done) seen_done++;
         step(1'b0, 13'd0, 1'b1, 1'b0);
      end
      check("abort no frame_done", 32'(seen_done), 32'd0);
      step(1'b1, 13'd2, 1'b1, 1'b0);
      check("restart busy", 32'(busy), 32'd1);
      check("restart mbnumber", 32'(mbnumber), 32'd0);
      repeat (9) step(1'b0, 13'd0, 1'b1, 1'b0);

      // ---- ignored starts ----------------------------------------------------
      step(1'b1, 13'd5, 1'b1, 1'b1);
      check("start+abort idle busy", 32'(busy), 32'd0);
      step(1'b1, 13'd4, 1'b1, 1'b0);
      step(1'b0, 13'd0, 1'b1, 1'b0);
      step(1'b1, 13'd9, 1'b1, 1'b0);
      check("start in RUN mbnumber", 32'(mbnumber), 32'd2);
      repeat (7) step(1'b0, 13'd0, 1'b1, 1'b0);
      check("frame_done cycle 10", 32'(frame_done), 32'd1);
      step(1'b0, 13'd0, 1'b1, 1'b0);
      check("busy drops cycle 11", 32'(busy), 32'd0);

      // ---- asynchronous reset while draining ---------------------------------
      step(1'b1, 13'd2, 1'b1, 1'b0);
      repeat (4) step(1'b0, 13'd0, 1'b1, 1'b0);
      check("drain before reset stage_valid", 32'(stage_valid), 32'b01100);
      #2;
      reset = 1'b1;
      #1;
      check("async reset enable", 32'(enable), 32'd0);
      check("async reset mbnumber", 32'(mbnumber), 32'd0);
      check("async reset stage_valid", 32'(stage_valid), 32'd0);
      check("async reset mb_retired", 32'(mb_retired), 32'd0);
      check("async reset retired_mbnumber", 32'(retired_mbnumber), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset frame_done", 32'(frame_done), 32'd0);
`ifdef INTRAPRED_SCHED_PERF_EN
      check("async reset frame_cycles", frame_cycles, 32'd0);
      check("async reset stall_cycles", stall_cycles, 32'd0);
`endif
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ---- random traffic against the model ----------------------------------
      for (int cyc = 0; cyc < 2500; cyc++) begin
         logic          st;
         logic          pr;
         logic          ab;
         logic [MW-1:0] n;
         st = ($urandom_range(0, 7) == 0);
         n  = MW'($urandom_range(0, 12));
         pr = ($urandom_range(0, 3) != 0);
         ab = ($urandom_range(0, 79) == 0);
         step(st, n, pr, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/intrapred_sched.md
# intrapred_sched

Frame-level scheduler for the intra-prediction pipeline. It walks macroblock numbers 0..num_mbs-1 through the extract → mode → residual → SAD → save chain. It drives the shared `enable`/`mbnumber` inputs of that chain and tracks which macroblock occupies each pipeline stage. It sits between the encoder top-level controller (start/abort/frame_done handshake) and the intra-prediction datapath (`enable`, `mbnumber`, `pipe_ready` backpressure from the saver stage).

## Interface
- MB_NUMBER_BITS, 12, macroblock index is MB_NUMBER_BITS+1 bits wide (matches datapath).
- PIPE_DEPTH, 5, number of datapath stages tracked (extract, mode, res, SAD, save).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process a frame; honoured only in IDLE.
- abort  in  1  cancel the current frame.
- num_mbs  in  MB_NUMBER_BITS+1  macroblocks in frame; sampled on accepted start.
- pipe_ready  in  1  datapath can advance this cycle.
- enable  out  1  pipeline advance strobe to all datapath stages.
- mbnumber  out  MB_NUMBER_BITS+1  macroblock being injected into stage 0.
- stage_valid  out  PIPE_DEPTH  stage i holds a real macroblock.
- mb_retired  out  1  macroblock leaves the last stage this cycle.
- retired_mbnumber  out  MB_NUMBER_BITS+1  tag of the retiring macroblock.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.

## Operation
- State machine: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: start with num_mbs≠0 → RUN, latch num_mbs, next_mb=0. start with num_mbs=0 → DONE directly.
- enable = (RUN or DRAIN) and pipe_ready. This is combinational from registered state and pipe_ready. Every other output is registered except mb_retired and retired_mbnumber.
- Advance (enable=1):
  - Stage tags and valids shift toward stage PIPE_DEPTH-1.
  - In RUN, stage 0 receives {valid=1, tag=next_mb}. In DRAIN, stage 0 receives a bubble.
- mbnumber = next_mb. next_mb increments on each RUN advance. When the advance issues num_mbs-1 → DRAIN.
- mb_retired = enable and stage_valid[PIPE_DEPTH-1]. retired_mbnumber = tag of the last stage.
- DRAIN: when the post-shift valid vector is all zero → DONE.
- DONE: frame_done=1 for exactly one cycle → IDLE.
- pipe_ready=0 freezes next_mb, stage registers and state. enable=0.
- abort, in any non-IDLE state: next edge clears all stage_valid and goes to IDLE. No frame_done pulse.
- abort and start in the same cycle in IDLE: abort wins, start is ignored.
- start while busy is ignored.
- Counters are MB_NUMBER_BITS+1 bits and never wrap: issue stops at num_mbs-1.

## Timing
- Reset values: state IDLE; enable 0; mbnumber 0; stage_valid 0; tags 0; mb_retired 0; retired_mbnumber 0; busy 0; frame_done 0.
- start accepted in cycle 0 → busy=1 and enable=1 (if pipe_ready) with mbnumber=0 in cycle 1.
- Without stalls:
  - Macroblock k is issued in cycle k+1 and retires (mb_retired=1) in cycle k+1+PIPE_DEPTH.
  - frame_done is high in cycle N+PIPE_DEPTH+1 (N=num_mbs). busy drops the following cycle.
- Each stall cycle delays all later events by one cycle.
- Throughput: one macroblock per advance.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous).

## Configuration
- INTRAPRED_SCHED_PERF_EN defined:
  - Adds outputs stall_cycles and frame_cycles, both 32-bit.
  - Both counters clear on accepted start.
  - frame_cycles counts every busy cycle.
  - stall_cycles counts RUN/DRAIN cycles with pipe_ready=0.
  - Both hold their value in IDLE. Both saturate at all-ones.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then start with num_mbs=3 and pipe_ready=1 → mbnumber 0,1,2 with enable=1 in cycles 1–3. mb_retired in cycles 6,7,8 with tags 0,1,2. frame_done in cycle 9. busy=0 in cycle 10.
- Same frame with pipe_ready=0 in cycles 2–3 → enable low and all state frozen in those cycles. Retires in cycles 8,9,10. frame_done in cycle 11. stall_cycles=2 when PERF enabled.
- start with num_mbs=0 → frame_done in cycle 1, enable never asserted, busy=0 in cycle 2.
- abort in cycle 4 of a 10-MB frame → stage_valid=0 and state IDLE in cycle 5. frame_done never pulses. A new start is then accepted normally.
- start pulsed again during RUN, and start+abort together in IDLE → both ignored: no restart, no change to next_mb.
- Asynchronous reset mid-DRAIN → all outputs return to reset values before the next clock edge.
